// File: rtl/key_edge_pio.sv
// key_edge_pio: Avalon-MM pushbutton input port. Each input bit is
// synchronised, debounced and edge-detected by its own lane; the top level
// holds the interrupt mask and the write-1-to-clear edge-capture register.

// Per-bit lane: two-flop synchroniser, debounce counter, edge detect.
module key_edge_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int EDGE_TYPE       = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic event_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  // Synchroniser idles at the raw level of a released key.
  localparam logic INACTIVE = ACTIVE_LOW;

  logic          sync1_q, sync2_q;
  logic          pressed;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          stable_prev_q;

  assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign level   = stable_q;

  // Debounce: any sample agreeing with the accepted level restarts the count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (pressed == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = pressed;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Select which debounced transitions count as events.
  always_comb begin
    case (EDGE_TYPE)
      0:       event_o = stable_q & ~stable_prev_q;
      1:       event_o = ~stable_q & stable_prev_q;
      default: event_o = stable_q ^ stable_prev_q;
    endcase
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= INACTIVE;
      sync2_q       <= INACTIVE;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
    end
  end
endmodule

module key_edge_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 1,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [WIDTH-1:0] level, evt;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             wr_en;
  logic             unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    key_edge_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW != 0),
      .EDGE_TYPE      (EDGE_TYPE)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (in_port[i]),
      .level  (level[i]),
      .event_o(evt[i])
    );
  end

  // Register writes; a new event beats a same-edge clear of that bit.
  always_comb begin
    mask_d    = mask_q;
    edgecap_d = edgecap_q;
    if (wr_en && address == 2'd1) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd3) edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    edgecap_d = edgecap_d | evt;
  end

  // Mask and edge-capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= '0;
      edgecap_q <= '0;
    end else begin
      mask_q    <= mask_d;
      edgecap_q <= edgecap_d;
    end
  end

  // Zero-wait-state read mux; upper bits always zero.
  always_comb begin
    case (address)
      2'd0:    readdata = 32'(level);
      2'd1:    readdata = 32'(mask_q);
      2'd3:    readdata = 32'(edgecap_q);
      default: readdata = 32'd0;
    endcase
  end

  assign irq = |(edgecap_q & mask_q);
endmodule

// File: tb/tb_key_edge_pio.sv
// Bench for key_edge_pio: two instances (press-only and both-edge capture)
// share stimulus; a history-window reference model predicts every register.
module tb_key_edge_pio;
  localparam int W  = 4;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   address;
  logic         chipselect, write_n;
  logic [31:0]  writedata;
  logic [W-1:0] in_port;
  logic [31:0]  rd0, rd2;
  logic         irq0, irq2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_edge_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  key_edge_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  // Reference model: the debouncer sees each sample two edges late and
  // accepts a new level once the last DC observations all disagree with it.
  bit [W-1:0] m_stable, m_mask, m_ec0, m_ec2, m_pend0, m_pend2;
  bit [W-1:0] pipe_q[$];
  bit [W-1:0] win[$];

  function automatic void model_reset();
    m_stable = '0; m_mask = '0; m_ec0 = '0; m_ec2 = '0;
    m_pend0 = '0; m_pend2 = '0;
    pipe_q = {4'h0, 4'h0};
    win.delete();
  endfunction

  function automatic void model_edge();
    bit [W-1:0] obs, nxt, rise, fall, clr;
    bit wr, all;
    pipe_q.push_back(~in_port);
    obs = pipe_q.pop_front();
    win.push_back(obs);
    if (win.size() > DC) void'(win.pop_front());
    nxt = m_stable;
    if (win.size() == DC)
      for (int i = 0; i < W; i++) begin
        all = 1'b1;
        foreach (win[k]) if (win[k][i] == m_stable[i]) all = 1'b0;
        if (all) nxt[i] = ~m_stable[i];
      end
    rise = nxt & ~m_stable;
    fall = ~nxt & m_stable;
    wr   = chipselect && !write_n;
    clr  = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    m_ec0 = (m_ec0 & ~clr) | m_pend0;
    m_ec2 = (m_ec2 & ~clr) | m_pend2;
    m_pend0 = rise;
    m_pend2 = rise | fall;
    if (wr && address == 2'd1) m_mask = writedata[W-1:0];
    m_stable = nxt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Read every address on both instances and compare against the model.
  task automatic check_all();
    logic [31:0] e0, e2;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      case (a)
        0:       begin e0 = 32'(m_stable); e2 = 32'(m_stable); end
        1:       begin e0 = 32'(m_mask);   e2 = 32'(m_mask);   end
        3:       begin e0 = 32'(m_ec0);    e2 = 32'(m_ec2);    end
        default: begin e0 = 32'd0;         e2 = 32'd0;         end
      endcase
      chk($sformatf("rd0_a%0d", a), rd0, e0);
      chk($sformatf("rd2_a%0d", a), rd2, e2);
    end
    chk("irq0", 32'(irq0), 32'(|(m_ec0 & m_mask)));
    chk("irq2", 32'(irq2), 32'(|(m_ec2 & m_mask)));
  endtask

  task automatic tick(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
    chipselect = cs; write_n = wn; address = a; writedata = wd;
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    chipselect = 1'b0; write_n = 1'b1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 2'd0, 32'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    tick(1'b1, 1'b0, a, d);
  endtask

  // Directed read of dut0 (and dut2 when a separate value is given).
  task automatic expect_rd(input string tag, input logic [1:0] a, input logic [31:0] e0, input logic [31:0] e2);
    address = a;
    #1;
    chk({tag, "_0"}, rd0, e0);
    chk({tag, "_2"}, rd2, e2);
  endtask

  initial begin
    int g;
    reset_n = 1'b0; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'd0;
    model_reset();

    // 1: reset state, writes to read-only/reserved addresses ignored
    #2;
    check_all();
    reset_n = 1'b1;
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd2, 32'hFFFF_FFFF);
    expect_rd("s1_data", 2'd0, 32'd0, 32'd0);
    expect_rd("s1_rsvd", 2'd2, 32'd0, 32'd0);

    // 2: press bit 0; data after edge 5, capture after edge 6
    in_port = 4'hE;
    idle(5);                                   // edges 0..4
    expect_rd("s2_data_e4", 2'd0, 32'h0, 32'h0);
    idle(1);                                   // edge 5
    expect_rd("s2_data_e5", 2'd0, 32'h1, 32'h1);
    expect_rd("s2_ec_e5", 2'd3, 32'h0, 32'h0);
    idle(1);                                   // edge 6
    expect_rd("s2_ec_e6", 2'd3, 32'h1, 32'h1);
    chk("s2_irq_unmasked", 32'(irq0), 32'd0);
    wr(2'd1, 32'h1);
    chk("s2_irq_masked", 32'(irq0), 32'd1);

    // 3: bounce bit 1, then hold it pressed from edge N
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) in_port[1] = ~in_port[1];
      idle(1);
      chk("s3_bounce_data1", 32'(rd0[1]), 32'd0);
    end
    in_port[1] = 1'b0;
    idle(5);                                   // edges N..N+4
    expect_rd("s3_data_n4", 2'd0, 32'h1, 32'h1);
    idle(1);                                   // edge N+5
    expect_rd("s3_data_n5", 2'd0, 32'h3, 32'h3);
    expect_rd("s3_ec_n5", 2'd3, 32'h1, 32'h1);
    idle(1);                                   // edge N+6
    expect_rd("s3_ec_n6", 2'd3, 32'h3, 32'h3);
    idle(3);
    expect_rd("s3_ec_once", 2'd3, 32'h3, 32'h3);

    // 4: write-1-to-clear with mask 0x3
    wr(2'd1, 32'h3);
    wr(2'd3, 32'h1);
    expect_rd("s4_ec_clr1", 2'd3, 32'h2, 32'h2);
    chk("s4_irq_still", 32'(irq0), 32'd1);
    wr(2'd3, 32'h2);
    expect_rd("s4_ec_clr2", 2'd3, 32'h0, 32'h0);
    chk("s4_irq_low", 32'(irq0), 32'd0);

    // 5: release bit 0: press-only ignores it, both-edge captures it
    in_port[0] = 1'b1;
    idle(8);
    expect_rd("s5_data_rel", 2'd0, 32'h2, 32'h2);
    expect_rd("s5_ec_rel", 2'd3, 32'h0, 32'h1);
    wr(2'd3, 32'hF);
    // new press of bit 0, cleared on the very edge that captures it
    in_port[0] = 1'b0;
    g = 0;
    address = 2'd0;
    #1;
    while (rd0[0] !== 1'b1 && g < 20) begin
      idle(1);
      address = 2'd0;
      #1;
      g++;
    end
    chk("s5_press_seen", 32'(rd0[0]), 32'd1);
    wr(2'd3, 32'h1);
    expect_rd("s5_set_wins", 2'd3, 32'h1, 32'h1);

    // 6: async reset mid-debounce with bit 2 held (cnt[2]=2 after edge 3)
    wr(2'd3, 32'hF);
    in_port = 4'hB;
    idle(4);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("s6_irq_rst", 32'(irq0), 32'd0);
    reset_n = 1'b1;
    idle(5);                                   // post-reset edges 0..4
    expect_rd("s6_data_e4", 2'd0, 32'h0, 32'h0);
    idle(1);                                   // edge 5
    expect_rd("s6_data_e5", 2'd0, 32'h4, 32'h4);
    idle(1);                                   // edge 6
    expect_rd("s6_ec_e6", 2'd3, 32'h4, 32'h4);

    // Random phase: slow and bouncy inputs mixed with random bus traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
      else if ($urandom_range(0, 7) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0)
        tick(1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom);
      else
        tick($urandom_range(0, 1) == 1, 1'b1, 2'($urandom_range(0, 3)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
